// File: rtl/cpu_pkg.sv
// Shared CPU constants: multiply/divide op encodings, muldiv FSM states,
// default datapath width. The ALU control decoder uses the same op constants.
package cpu_pkg;

  localparam int XLEN = 32;

  // Multiply/divide unit operation encodings (values 6 and 7 are no-ops).
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider. Multiply is a shift-add
// on {acc_hi, acc_lo} with the multiplier consumed LSB-first from acc_lo;
// divide is a restoring step on {R = acc_hi, Q = acc_lo}.
module muldiv_step #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Single combinational step, selected by is_div.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can leave it unassigned (which would infer a latch).
    next_hi = acc_hi;
    next_lo = acc_lo;
    // The carry out of the add lands in bit XLEN and shifts back into the upper half.
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // R is always below the divisor, so the shifted remainder fits in XLEN+1 bits
    // and the sign of the XLEN+1-bit difference is the trial-subtract verdict.
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      if (!diff[XLEN]) begin
        next_hi = diff[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        next_hi = shifted[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[XLEN:1];
      next_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// XLEN iterations in CALC, one sign-fix cycle in FIX, done pulses as HI/LO update.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, opnd_q, a_raw_q;
  logic            is_div_q, res_neg_q, rem_neg_q, div0_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            done_q;

  // Issue decode and operand magnitudes (XLEN+1-bit negate keeps |MIN| exact).
  logic            is_arith, is_div, is_signed, a_neg, b_neg;
  logic [XLEN:0]   a_negated, b_negated;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            unused_neg_msb;

  assign is_arith  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = is_signed && a[XLEN-1];
  assign b_neg     = is_signed && b[XLEN-1];
  assign a_negated = '0 - {a[XLEN-1], a};
  assign b_negated = '0 - {b[XLEN-1], b};
  assign a_mag     = a_neg ? a_negated[XLEN-1:0] : a;
  assign b_mag     = b_neg ? b_negated[XLEN-1:0] : b;
  assign unused_neg_msb = a_negated[XLEN] ^ b_negated[XLEN];

  logic [XLEN-1:0] step_hi, step_lo;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (opnd_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Sign fix-up applied to the finished magnitude result.
  logic [2*XLEN-1:0] prod, prod_negated;
  logic [XLEN-1:0]   quo_negated, rem_negated, fix_hi, fix_lo;

  assign prod         = {acc_hi_q, acc_lo_q};
  assign prod_negated = '0 - prod;
  assign quo_negated  = '0 - acc_lo_q;
  assign rem_negated  = '0 - acc_hi_q;

  always_comb begin
    fix_hi = res_neg_q ? prod_negated[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    fix_lo = res_neg_q ? prod_negated[XLEN-1:0] : prod[XLEN-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem_neg_q ? rem_negated : acc_hi_q;
        fix_lo = res_neg_q ? quo_negated : acc_lo_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: flush aborts in-flight work and blocks a same-cycle issue.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !flush && is_arith) state_d = S_CALC;
      S_CALC:  if (flush) state_d = S_IDLE;
               else if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start && !flush) begin
          if (is_arith) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= is_div ? a_mag : b_mag;
            opnd_q    <= is_div ? b_mag : a_mag;
            a_raw_q   <= a;
            is_div_q  <= is_div;
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= is_div && (b == '0);
          end else if (op == MD_MTHI) begin
            hi_q <= a;
          end else if (op == MD_MTLO) begin
            lo_q <= a;
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_FIX: if (!flush) begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: arithmetic vectors with exact latency,
// MTHI/MTLO, flush, start-while-busy, no-op codes and mid-operation reset.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    vec_t vecs[9];
    int   bad;
    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[2] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
    vecs[4] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"};
    vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
    vecs[6] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0"};
    vecs[7] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0"};
    vecs[8] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    foreach (vecs[i]) begin
      @(negedge clk);
      start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      start = 1'b0;
      bad = 0;
      for (int c = 1; c <= W + 1; c++) begin
        if (c > 1) @(negedge clk);
        if ((busy !== 1'b1 || done !== 1'b0) && bad == 0) bad = c;
      end
      n_vec++;
      if (bad != 0) begin
        n_err++; $display("FAIL %s_busy_window: busy/done wrong at cycle T+%0d (busy=%b done=%b), want busy=1 done=0", vecs[i].name, bad, busy, done);
      end
      @(negedge clk);
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b want 1", vecs[i].name, done); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_end: got %b want 0", vecs[i].name, busy); end
      n_vec++; if (hi !== vecs[i].hi) begin n_err++; $display("FAIL %s_hi: got %h want %h", vecs[i].name, hi, vecs[i].hi); end
      n_vec++; if (lo !== vecs[i].lo) begin n_err++; $display("FAIL %s_lo: got %h want %h", vecs[i].name, lo, vecs[i].lo); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_pulse: got %b want 0", vecs[i].name, done); end
    end
  endtask

  task automatic test_move();
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mthi_hi: got %h want a5a5a5a5", hi); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi_flags: busy=%b done=%b want 0 0", busy, done); end
    start = 1'b1; op = MD_MTLO; a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (lo !== 32'h0BADF00D) begin n_err++; $display("FAIL mtlo_lo: got %h want 0badf00d", lo); end
    n_vec++; if (hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want a5a5a5a5", hi); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mtlo_flags: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_noop();
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h12345678; b = 32'h9;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL noop_busy: got %b want 0", busy); end
    n_vec++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h0BADF00D) begin n_err++; $display("FAIL noop_hilo: got %h/%h want a5a5a5a5/0badf00d", hi, lo); end
  endtask

  task automatic test_flush();
    int seen_done;
    // Flush in IDLE suppresses a same-cycle MTHI and a same-cycle divide.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MD_MTHI; a = 32'h11111111;
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_vec++; if (hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL flush_idle_mthi: got %h want a5a5a5a5", hi); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_div_busy: got %b want 0", busy); end
    // Abort an in-flight DIVU with flush at T+10.
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_drop: got %b want 0", busy); end
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1;
    end
    n_vec++; if (seen_done != 0) begin n_err++; $display("FAIL flush_no_done: activity after flush, want none"); end
    n_vec++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h0BADF00D) begin n_err++; $display("FAIL flush_hilo: got %h/%h want a5a5a5a5/0badf00d", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int extra;
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;                                   // cycle T+1
    repeat (2) @(negedge clk);                      // cycle T+3
    start = 1'b1; op = MD_MTLO; a = 32'h0000DEAD;
    @(negedge clk);                                 // cycle T+4
    op = MD_MULT; a = 32'd7; b = 32'd7;
    @(negedge clk);                                 // cycle T+5
    start = 1'b0;
    n_vec++; if (lo !== 32'h0BADF00D) begin n_err++; $display("FAIL busy_mtlo_ignored: got %h want 0badf00d", lo); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_still: got %b want 1", busy); end
    repeat (29) @(negedge clk);                     // cycle T+34
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
    n_vec++; if (hi !== 32'd0 || lo !== 32'd30) begin n_err++; $display("FAIL b2b_result: got %h/%h want 00000000/0000001e", hi, lo); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra = 1;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL b2b_not_queued: unit went busy again, want idle"); end
  endtask

  task automatic test_reset_mid();
    int extra;
    @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;                                   // cycle T+1
    repeat (4) @(negedge clk);                      // cycle T+5
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_vec++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL midreset_hilo: got %h/%h want 0/0", hi, lo); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra = 1;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL midreset_quiet: activity after reset, want none"); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_move();
    test_noop();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
